// File: rtl/muskbus_line_reader.sv
// Muskbus line reader: turns a single-word core read into a full cache-line
// burst on Muskbus and hands back the assembled line. Holds bid from the
// first request cycle through the last response beat.
module muskbus_line_reader #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8,
    parameter int TAG_ID = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_valid,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_ready,
    output logic                     line_valid,
    output logic [DATA_W*BEATS-1:0]  line_data,
    input  logic                     line_ready,
    output logic                     bid,
    output logic                     reqcyc,
    output logic [DATA_W-1:0]        req,
    output logic [TAG_W-1:0]         reqtag,
    input  logic                     reqack,
    input  logic                     respcyc,
    input  logic [DATA_W-1:0]        resp,
    output logic                     respack
);

    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [TAG_W-1:0]  TAG_VAL    = {1'b1, (TAG_W-1)'(TAG_ID)};
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W*BEATS-1:0] line_q;
    logic                    rdy_q, bid_q, reqcyc_q, lv_q;
    logic                    accept, beat;

    // Next-state decode, acceptance and beat strobes.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        beat    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_valid && rdy_q) begin
                    accept  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (reqack) state_n = RESP;
            end
            RESP: begin
                if (respcyc) begin
                    beat = 1'b1;
                    if (cnt == LAST_BEAT) state_n = DONE;
                end
            end
            DONE: begin
                if (line_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register with outputs registered from the next state; the
    // ready flag stays low during reset and rises one cycle after release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rdy_q    <= 1'b0;
            bid_q    <= 1'b0;
            reqcyc_q <= 1'b0;
            lv_q     <= 1'b0;
        end else begin
            state    <= state_n;
            rdy_q    <= (state_n == IDLE);
            bid_q    <= (state_n == REQ) || (state_n == RESP);
            reqcyc_q <= (state_n == REQ);
            lv_q     <= (state_n == DONE);
        end
    end

    // Address latch, beat counter and line assembly buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            addr_q <= '0;
            line_q <= '0;
        end else begin
            if (accept) addr_q <= rd_addr & ALIGN_MASK;
            if (state == REQ && reqack) cnt <= '0;
            if (beat) begin
                line_q[int'(cnt)*DATA_W +: DATA_W] <= resp;
                cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
            end
        end
    end

    assign rd_ready   = rdy_q;
    assign line_valid = lv_q;
    assign line_data  = line_q;
    assign bid        = bid_q;
    assign reqcyc     = reqcyc_q;
    assign req        = reqcyc_q ? DATA_W'(addr_q) : '0;
    assign reqtag     = reqcyc_q ? TAG_VAL : '0;
    // Beats are acknowledged in the same cycle, never while reset is held.
    assign respack    = beat && reset;

endmodule

// File: doc/muskbus_line_reader.md
# muskbus_line_reader

Bus master that turns a single-word read request from a core-side unit into a full cache-line read on Muskbus, then returns the assembled line. It connects to one bottom port of the Muskbus arbiter/mux and holds `bid` for the whole transaction, from request through the last response beat. Core-side units such as the I-cache and D-cache fill paths use one instance each.

## Interface
- `ADDR_W`, 64: request address width.
- `DATA_W`, 64: bus data width (`req`, `resp`).
- `TAG_W`, 13: `reqtag` width.
- `BEATS`, 8: response beats per line; power of two, at least 2.
- `TAG_ID`, 0: per-instance tag payload, TAG_W-1 bits.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset; 0 = reset.
- `rd_valid`  in  1  core read request valid.
- `rd_addr`  in  ADDR_W  byte address of the requested word.
- `rd_ready`  out  1  block can accept a request.
- `line_valid`  out  1  assembled line available.
- `line_data`  out  DATA_W*BEATS  line; beat i occupies `[i*DATA_W +: DATA_W]`.
- `line_ready`  in  1  core consumes the line.
- `bid`  out  1  bus ownership request to the arbiter.
- `reqcyc`  out  1  request cycle valid.
- `req`  out  DATA_W  line-aligned request address.
- `reqtag`  out  TAG_W  `{1'b1 (read), TAG_ID}`.
- `reqack`  in  1  bus accepted the request.
- `respcyc`  in  1  response beat valid.
- `resp`  in  DATA_W  response beat data.
- `respack`  out  1  response beat acknowledged.

## Operation
- FSM states are IDLE, REQ, RESP and DONE. There is also a beat counter `cnt` of clog2(BEATS) bits.
- **IDLE**
  - `rd_ready`=1; `rd_valid&&rd_ready` latches the address and moves to REQ.
  - The latched address has its low clog2(BEATS*DATA_W/8) bits forced to 0.
- **REQ**
  - Drives `bid`=1, `reqcyc`=1, `req`=latched address and `reqtag`={1,TAG_ID}.
  - Holds all of these until a cycle with `reqack`=1, then moves to RESP with `cnt`=0.
  - `respcyc` in REQ, including the `reqack` cycle, is ignored and `respack`=0.
- **RESP**
  - `bid`=1 and `reqcyc`=0.
  - `respack` = `respcyc`, combinational in the same cycle.
  - On each `respcyc`, `resp` is written to slot `cnt` and `cnt` increments.
  - On the beat where `cnt`==BEATS-1, `cnt` wraps to 0 and the FSM moves to DONE.
- **DONE**
  - `bid`=0 and `line_valid`=1; `line_data` is stable.
  - `line_ready`=1 moves to IDLE.
  - `rd_ready`=0; there is no same-cycle turnaround.
- `respcyc` seen in IDLE or DONE: `respack`=0, data discarded, state unchanged.
- `line_data` keeps the last line after DONE until it is overwritten beat by beat in the next RESP.
- `rd_addr` is sampled only on acceptance; later changes have no effect.

## Timing
- Reset (`reset`=0 at a clock edge): state=IDLE, `cnt`=0, address register 0, `line_data` 0.
- Outputs in reset: `bid`=0, `reqcyc`=0, `respack`=0, `line_valid`=0. `rd_ready` becomes 1 on the first cycle after reset is released.
- Reset mid-transaction: return to IDLE immediately and drop `bid`. Any further bus beats are then ignored, as in IDLE.
- Cycle numbering, with acceptance at edge 0:
  - cycle 1: REQ.
  - If `reqack` arrives in cycle 1, beats can occupy cycles 2..BEATS+1.
  - `line_valid` rises in cycle BEATS+2 at the earliest.
- Minimum accept-to-`line_valid` latency is BEATS+2 cycles; the gaps between beats are arbitrary.
- `bid` is a registered function of state: high from the first REQ cycle through the last-beat cycle. It is low in DONE, which lets the arbiter go idle.
- `reqcyc`, `req` and `reqtag` are registered-stable throughout REQ.
- `respack` is the only combinational output.

## Test plan
- **Basic read:** `rd_addr`=0x1234, `reqack` in first REQ cycle, 8 back-to-back beats 0..7 ->
  - `req`=0x1200 and `reqtag`=0x1000 (TAG_ID=0).
  - `line_valid` in cycle 10, slot i = i.
  - `bid` falls in cycle 10.
- **Delayed ack:** `reqack` held low 5 cycles -> `reqcyc`, `req` and `bid` remain stable for all 6 REQ cycles; a `respcyc` pulse during REQ gets `respack`=0 and is not stored.
- **Gapped beats:** 8 beats separated by 0-3 idle cycles ->
  - `respack` mirrors `respcyc` exactly.
  - The line is assembled in order.
  - `cnt` wraps to 0.
- **Backpressure:** `line_ready`=0 for 4 cycles in DONE ->
  - `line_valid` and `line_data` are held.
  - `rd_ready`=0; a new `rd_valid` is not accepted until the cycle after `line_ready`=1.
- **Reset mid-RESP:** `reset`=0 after beat 3 -> next cycle `bid`=0 and `line_valid`=0, and `line_data` reads 0. After release, a fresh read completes correctly with `cnt` restarting at 0.
- **Stray response:** `respcyc`=1 in IDLE and in DONE -> `respack`=0, `line_data` unchanged, state unchanged.
